inst_fetch: RTL and testbench

Instruction fetch unit: the initiator side of the combinational instruction ROM port (`addr` / `data` / `accessable`). Holds the program counter, drives the ROM address, and captures each returned word plus its PC into a one-entry output register handed to decode with a valid/ready handshake. Inaccessible or misaligned fetches become a fault-tagged slot, and fetch halts until the core redirects. Sits between the ROM and the decode stage.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/fetch_out_buf.sv | 46 ++++
 rtl/inst_fetch.sv | 98 +++++++++
 tb/tb_inst_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: FSM encodings, boot address, fault filler word, slot payload.
// The core reuses RESET_PC_DEF and NOP_WORD_DEF for its redirect and exception vectors.
package inst_fetch_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry output register between fetch and decode, with flush.
// Latency: written word visible the cycle after write; backpressure: holds payload while !rdy_i.
// Refill on the accepting cycle is allowed, so a stream with rdy_i high has no bubbles.
module fetch_out_buf
    import inst_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_vld_i,
    input  fetch_slot_t wr_dat_i,
    input  logic        flush_i,
    input  logic        rdy_i,
    output logic        vld_o,
    output fetch_slot_t dat_o
);

    logic        vld_q, vld_d;
    fetch_slot_t dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (wr_vld_i) begin
            vld_d = 1'b1;
            dat_d = wr_dat_i;
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, ROM address, fault halt, and accepted-slot counter.
// Latency: rom_addr in cycle N -> inst in N+1; backpressure: PC frozen while slot held unaccepted.
// A fetch the ROM rejects becomes a fault slot and fetch halts until a redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        rom_accessable_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_fault_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         capture;
    logic         slot_vld;
    fetch_slot_t  slot_wr, slot_dat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid_i) begin
            state_d = ST_RUN;
        end else if (capture && !rom_accessable_i) begin
            state_d = ST_HALT;
        end
    end

    always_comb begin
        capture = (state_q == ST_RUN) && (!slot_vld || inst_ready_i) && !redirect_valid_i;
    end

    // A faulting fetch leaves the PC on the bad address so the halt is observable on rom_addr.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (capture && rom_accessable_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (slot_vld && inst_ready_i && !redirect_valid_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_comb begin
        slot_wr.inst  = rom_accessable_i ? rom_data_i : NOP_WORD;
        slot_wr.pc    = pc_q;
        slot_wr.fault = !rom_accessable_i;
    end

    fetch_out_buf u_out_buf (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .wr_vld_i (capture),
        .wr_dat_i (slot_wr),
        .flush_i  (redirect_valid_i),
        .rdy_i    (inst_ready_i),
        .vld_o    (slot_vld),
        .dat_o    (slot_dat)
    );

    assign rom_addr_o    = pc_q;
    assign inst_valid_o  = slot_vld;
    assign inst_o        = slot_dat.inst;
    assign inst_pc_o     = slot_dat.pc;
    assign inst_fault_o  = slot_dat.fault;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a ROM model and an expected-slot scoreboard.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_acc;
    logic        redir;
    logic [31:0] redir_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];

    inst_fetch dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .rom_addr_o       (rom_addr),
        .rom_data_i       (rom_data),
        .rom_accessable_i (rom_acc),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .inst_fault_o     (inst_fault),
        .fetch_count_o    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: boot words, an aligned region at 0x0040_00xx, and the top word.
    always_comb begin
        rom_acc  = 1'b0;
        rom_data = 32'h0;
        case (rom_addr)
            32'h0000_0000: begin rom_acc = 1'b1; rom_data = 32'h3c11_0040; end
            32'h0000_0004: begin rom_acc = 1'b1; rom_data = 32'h0810_0053; end
            32'h0000_0008: begin rom_acc = 1'b1; rom_data = 32'h0220_0008; end
            32'hFFFF_FFFC: begin rom_acc = 1'b1; rom_data = 32'hDEAD_BEEF; end
            default: begin
                if (rom_addr[31:8] == 24'h004000 && rom_addr[1:0] == 2'b00) begin
                    rom_acc  = 1'b1;
                    rom_data = rom_addr ^ 32'hA5A5_0000;
                end
            end
        endcase
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic f);
        exp_t e;
        e.inst  = i;
        e.pc    = p;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted (non-flushed) slot must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redir) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_slot: got pc %h inst %h, expected none", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("slot_inst", inst, e.inst);
                check32("slot_pc", inst_pc, e.pc);
                check32("slot_fault", {31'b0, inst_fault}, {31'b0, e.fault});
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        redir      = 1'b0;
        redir_pc   = 32'h0;
        repeat (2) tick();
        check32("rst_valid", {31'b0, inst_valid}, 32'd0);
        check32("rst_rom_addr", rom_addr, 32'h0);
        check32("rst_count", fetch_count, 32'd0);
        check32("rst_inst", inst, 32'h0);

        // Boot: three words back to back, then the fault at 0xC.
        push(32'h3c11_0040, 32'h0, 1'b0);
        push(32'h0810_0053, 32'h4, 1'b0);
        push(32'h0220_0008, 32'h8, 1'b0);
        push(32'h0000_0000, 32'hC, 1'b1);
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        tick();
        check32("boot_first_valid", {31'b0, inst_valid}, 32'd1);
        check32("boot_first_pc", inst_pc, 32'h0);
        tick();
        tick();
        tick();
        check32("boot_count", fetch_count, 32'd3);
        check32("fault_flag", {31'b0, inst_fault}, 32'd1);
        check32("fault_pc", inst_pc, 32'hC);
        tick();
        for (int i = 0; i < 10; i++) begin
            check32("halt_valid", {31'b0, inst_valid}, 32'd0);
            tick();
        end
        check32("halt_rom_addr", rom_addr, 32'hC);
        check32("halt_count", fetch_count, 32'd4);

        // Resume from 0, then stall on the 0x4 slot.
        redir    = 1'b1;
        redir_pc = 32'h0;
        tick();
        redir = 1'b0;
        check32("resume_rom_addr", rom_addr, 32'h0);
        push(32'h3c11_0040, 32'h0, 1'b0);
        push(32'h0810_0053, 32'h4, 1'b0);
        tick();
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check32("bp_valid", {31'b0, inst_valid}, 32'd1);
            check32("bp_pc", inst_pc, 32'h4);
            check32("bp_inst", inst, 32'h0810_0053);
            check32("bp_rom_addr", rom_addr, 32'h8);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check32("bp_next_pc", inst_pc, 32'h8);
        check32("bp_count", fetch_count, 32'd6);

        // Redirect flushes the unaccepted 0x8 slot, even with ready high.
        redir      = 1'b1;
        redir_pc   = 32'h0040_0000;
        inst_ready = 1'b1;
        tick();
        check32("redir_dropped", {31'b0, inst_valid}, 32'd0);
        check32("redir_rom_addr", rom_addr, 32'h0040_0000);
        check32("redir_count", fetch_count, 32'd6);
        redir      = 1'b0;
        inst_ready = 1'b0;
        push(32'hA5E5_0000, 32'h0040_0000, 1'b0);
        tick();
        check32("redir_target_valid", {31'b0, inst_valid}, 32'd1);
        check32("redir_target_pc", inst_pc, 32'h0040_0000);
        inst_ready = 1'b1;
        tick();

        // Misaligned redirect flushes 0x0040_0004 and faults at 0x0040_0002.
        redir      = 1'b1;
        redir_pc   = 32'h0040_0002;
        inst_ready = 1'b0;
        tick();
        redir      = 1'b0;
        inst_ready = 1'b1;
        push(32'h0000_0000, 32'h0040_0002, 1'b1);
        tick();
        check32("mis_fault", {31'b0, inst_fault}, 32'd1);
        check32("mis_pc", inst_pc, 32'h0040_0002);
        tick();
        for (int i = 0; i < 3; i++) begin
            check32("mis_halt_valid", {31'b0, inst_valid}, 32'd0);
            check32("mis_halt_addr", rom_addr, 32'h0040_0002);
            tick();
        end
        check32("mis_count", fetch_count, 32'd8);

        // PC wrap from the top word, then asynchronous reset mid-stream.
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        tick();
        redir = 1'b0;
        check32("wrap_rom_addr_top", rom_addr, 32'hFFFF_FFFC);
        push(32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0);
        tick();
        check32("wrap_rom_addr", rom_addr, 32'h0);
        tick();
        check32("wrap_next_pc", inst_pc, 32'h0);
        check32("wrap_count", fetch_count, 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check32("arst_valid", {31'b0, inst_valid}, 32'd0);
        check32("arst_rom_addr", rom_addr, 32'h0);
        check32("arst_count", fetch_count, 32'd0);
        repeat (2) tick();
        check32("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
